// File: rtl/param_seq_det.sv
// Parameterised serial pattern detector with a runtime-loadable pattern, length and overlap mode.
// It produces a combinational detect pulse plus a saturating detection counter with a sticky saturation flag.
module param_seq_det #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               seq_in,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  input  logic               cnt_clr,
  output logic               det,
  output logic [CNT_W-1:0]   det_cnt,
  output logic               cnt_sat,
  output logic               cfg_err
);

  localparam int FILL_W = $clog2(MAX_LEN + 1);

  typedef enum logic [0:0] {
    ST_UNCFG = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  // Bit i is set when bit i of the history takes part in the comparison.
  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [MAX_LEN-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      m[i] = (i < int'(len));
    end
    return m;
  endfunction

  function automatic logic len_bad(input logic [LEN_W-1:0] len);
    return (int'(len) < 2) || (int'(len) > MAX_LEN);
  endfunction

  state_t             state_q,   state_d;
  logic [MAX_LEN-1:0] hist_q,    hist_d;
  logic [FILL_W-1:0]  fill_q,    fill_d;
  logic [MAX_LEN-1:0] cfg_pat_q, cfg_pat_d;
  logic [LEN_W-1:0]   cfg_len_q, cfg_len_d;
  logic               cfg_ovl_q, cfg_ovl_d;
  logic               cfg_err_q, cfg_err_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               sat_q,     sat_d;

  logic [MAX_LEN-1:0] hist_nxt_s;
  logic [FILL_W-1:0]  fill_nxt_s;
  logic               accept_s;
  logic               match_s;

  // Shift/fill look-ahead, match evaluation and next-state for all registers.
  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    cfg_pat_d = cfg_pat_q;
    cfg_len_d = cfg_len_q;
    cfg_ovl_d = cfg_ovl_q;
    cfg_err_d = cfg_err_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;

    accept_s   = in_valid & ~cfg_load;
    hist_nxt_s = (hist_q << 1) | {{(MAX_LEN-1){1'b0}}, seq_in};
    if (fill_q == FILL_W'(MAX_LEN)) begin
      fill_nxt_s = fill_q;
    end else begin
      fill_nxt_s = fill_q + {{(FILL_W-1){1'b0}}, 1'b1};
    end

    match_s = accept_s & ~cfg_err_q & (state_q == ST_ARMED)
            & (int'(fill_nxt_s) >= int'(cfg_len_q))
            & (((hist_nxt_s ^ cfg_pat_q) & len_mask(cfg_len_q)) == '0);

    case (state_q)
      ST_UNCFG: state_d = cfg_load ? ST_ARMED : ST_UNCFG;
      ST_ARMED: state_d = ST_ARMED;
      default:  state_d = ST_UNCFG;
    endcase

    if (cfg_load) begin
      cfg_pat_d = pattern;
      cfg_len_d = pat_len;
      cfg_ovl_d = overlap;
      cfg_err_d = len_bad(pat_len);
      hist_d    = '0;
      fill_d    = '0;
    end else if (in_valid) begin
      hist_d = hist_nxt_s;
      // Non-overlapping mode restarts the window so the next hit needs fresh bits.
      fill_d = (match_s && !cfg_ovl_q) ? '0 : fill_nxt_s;
    end else begin
      hist_d = hist_q;
      fill_d = fill_q;
    end

    if (cnt_clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (match_s) begin
      if (&cnt_q) begin
        cnt_d = cnt_q;
        sat_d = 1'b1;
      end else begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        sat_d = sat_q;
      end
    end else begin
      cnt_d = cnt_q;
      sat_d = sat_q;
    end
  end

  // State, history, configuration and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_UNCFG;
      hist_q    <= '0;
      fill_q    <= '0;
      cfg_pat_q <= '0;
      cfg_len_q <= '0;
      cfg_ovl_q <= 1'b0;
      cfg_err_q <= 1'b1;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      cfg_pat_q <= cfg_pat_d;
      cfg_len_q <= cfg_len_d;
      cfg_ovl_q <= cfg_ovl_d;
      cfg_err_q <= cfg_err_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
    end
  end

  assign det     = match_s;
  assign det_cnt = cnt_q;
  assign cnt_sat = sat_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_param_seq_det.sv
// Randomised and directed bench for param_seq_det, checked against a queue-based model of the received bit stream.
module tb_param_seq_det;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               seq_in, in_valid, cfg_load, overlap, cnt_clr;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   pat_len;
  logic               det;
  logic [CNT_W-1:0]   det_cnt;
  logic               cnt_sat, cfg_err;

  param_seq_det #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .seq_in(seq_in), .in_valid(in_valid), .cfg_load(cfg_load),
    .pattern(pattern), .pat_len(pat_len), .overlap(overlap), .cnt_clr(cnt_clr),
    .det(det), .det_cnt(det_cnt), .cnt_sat(cnt_sat), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the bits received since the last load/reset/non-overlap hit.
  bit           m_bits[$];
  logic [7:0]   m_pat;
  int           m_len;
  bit           m_ovl, m_err, m_armed, m_sat;
  int           m_cnt;
  bit           exp_det;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_pat = 8'h00; m_len = 0; m_ovl = 1'b0; m_err = 1'b1; m_armed = 1'b0;
    m_cnt = 0; m_sat = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_cnt"}, 32'(det_cnt), 32'(m_cnt));
    check({tag, "_sat"}, 32'(cnt_sat), 32'(m_sat));
    check({tag, "_err"}, 32'(cfg_err), 32'(m_err));
  endtask

  task automatic step(input bit v, input bit b, input bit ld, input logic [7:0] p,
                      input int l, input bit o, input bit clr);
    @(negedge clk);
    in_valid = v; seq_in = b; cfg_load = ld; pattern = p; pat_len = LEN_W'(l);
    overlap = o; cnt_clr = clr;
    #1;
    exp_det = 1'b0;
    if (ld) begin
      m_bits.delete();
    end else if (v) begin
      m_bits.push_back(b);
      if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
      if (m_armed && !m_err && m_bits.size() >= m_len) begin
        exp_det = 1'b1;
        for (int i = 0; i < m_len; i++)
          if (m_bits[m_bits.size()-1-i] != m_pat[i]) exp_det = 1'b0;
      end
    end
    check("det", 32'(det), 32'(exp_det));
    if (ld) begin
      m_pat = p; m_len = l; m_ovl = o; m_err = (l < 2) || (l > MAX_LEN); m_armed = 1'b1;
    end else if (exp_det && !m_ovl) begin
      m_bits.delete();
    end
    if (clr) begin
      m_cnt = 0; m_sat = 1'b0;
    end else if (exp_det) begin
      if (m_cnt == (1 << CNT_W) - 1) m_sat = 1'b1;
      else m_cnt++;
    end
    @(posedge clk); #1;
    check_regs("post");
  endtask

  task automatic feed(input bit v, input bit b);
    step(v, b, 1'b0, 8'h00, 0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [7:0] p, input int l, input bit o);
    step(1'b0, 1'b0, 1'b1, p, l, o, 1'b0);
  endtask

  task automatic clear();
    step(1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1);
  endtask

  task automatic pulse_reset();
    @(negedge clk); #2;
    in_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_det", 32'(det), 32'd0);
    check_regs("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [7:0] seq8;
  int         r, l;

  initial begin
    rst_n = 1'b0; seq_in = 1'b0; in_valid = 1'b0; cfg_load = 1'b0; overlap = 1'b0;
    cnt_clr = 1'b0; pattern = '0; pat_len = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_det", 32'(det), 32'd0);
    check_regs("reset");
    rst_n = 1'b1;

    // 101 overlapping on 1,0,1,0,1: hits on bits 3 and 5.
    load(8'b101, 3, 1'b1);
    feed(1, 1); feed(1, 0); feed(1, 1); feed(1, 0); feed(1, 1);
    check("ovl_cnt", 32'(det_cnt), 32'd2);

    // Same stream non-overlapping: only bit 3 hits.
    clear();
    load(8'b101, 3, 1'b0);
    feed(1, 1); feed(1, 0); feed(1, 1); feed(1, 0); feed(1, 1);
    check("novl_cnt", 32'(det_cnt), 32'd1);

    // Eight-bit pattern with invalid gaps between bits.
    clear();
    seq8 = 8'b11010011;
    load(seq8, 8, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      feed(1, seq8[i]);
      feed(0, ~seq8[i]);
    end
    check("gap_cnt", 32'(det_cnt), 32'd1);

    // Saturation with a 2-bit counter and pattern 11.
    clear();
    load(8'b11, 2, 1'b1);
    for (int i = 0; i < 6; i++) feed(1, 1);
    check("sat_cnt", 32'(det_cnt), 32'd3);
    check("sat_flag", 32'(cnt_sat), 32'd1);
    clear();
    check("clr_cnt", 32'(det_cnt), 32'd0);

    // Clear colliding with a hit: clear wins, det still pulses.
    load(8'b11, 2, 1'b1);
    feed(1, 1);
    step(1, 1, 0, 8'h00, 0, 0, 1);

    // Partial history discarded by reset.
    load(8'b101, 3, 1'b1);
    feed(1, 1); feed(1, 0);
    pulse_reset();
    load(8'b101, 3, 1'b1);
    feed(1, 1);

    // Illegal length keeps the detector silent.
    load(8'h00, 0, 1'b1);
    for (int i = 0; i < 6; i++) feed(1, 0);
    check("len0_err", 32'(cfg_err), 32'd1);
    load(8'hff, 9, 1'b1);
    for (int i = 0; i < 10; i++) feed(1, 1);

    // Load colliding with the completing bit: no hit, history restarts.
    clear();
    load(8'b101, 3, 1'b0);
    feed(1, 1); feed(1, 0);
    step(1, 1, 1, 8'b101, 3, 1'b0, 1'b0);
    feed(1, 0); feed(1, 1); feed(1, 1); feed(1, 0); feed(1, 1);

    // Randomised traffic.
    load(8'b01, 2, 1'b1);
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 199);
      if (r == 0) begin
        pulse_reset();
      end else if (r < 10) begin
        l = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 9) : $urandom_range(2, 4);
        step($urandom_range(0, 1), $urandom_range(0, 1), 1'b1, 8'($urandom),
             l, $urandom_range(0, 1), $urandom_range(0, 7) == 0);
      end else begin
        step($urandom_range(0, 4) != 0, $urandom_range(0, 1), 1'b0, 8'h00, 0, 1'b0,
             $urandom_range(0, 29) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
